// File: rtl/jac_mmio_pkg.sv
// Shared MMIO definitions for jacaranda-8 peripherals: register offsets, CTRL bits, widths.
package jac_mmio_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned MAX_SRC  = 8;
    localparam int unsigned ID_W     = 3;

    // Register offsets inside a peripheral window
    localparam int unsigned OFF_IE   = 0;
    localparam int unsigned OFF_IP   = 1;
    localparam int unsigned OFF_MODE = 2;
    localparam int unsigned OFF_CTRL = 3;
    localparam int unsigned OFF_VEC0 = 4;

    // CTRL bit positions
    localparam int unsigned CTRL_GIE_BIT = 0;
    localparam int unsigned CTRL_EOI_BIT = 1;
    localparam int unsigned CTRL_ID_LSB  = 4;
    localparam int unsigned CTRL_SVC_BIT = 7;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } disp_state_e;

endpackage

// File: rtl/jac_int_ctrl_if.sv
// CPU-side data bus and interrupt handshake of the interrupt controller.
interface jac_int_ctrl_if;
    import jac_mmio_pkg::*;

    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] w_data;
    logic              w_en;
    logic [DATA_W-1:0] r_data;
    logic              hit;
    logic              int_req;
    logic [DATA_W-1:0] int_en;
    logic [DATA_W-1:0] int_vec;

    modport master (
        output addr, w_data, w_en,
        input  r_data, hit, int_req, int_en, int_vec
    );

    modport slave (
        input  addr, w_data, w_en,
        output r_data, hit, int_req, int_en, int_vec
    );

endinterface

// File: rtl/jac_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module jac_prio_enc
    import jac_mmio_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]    req_i,
    output logic [ID_W-1:0] id_o,
    output logic            valid_o
);

    // Scan high to low so the lowest set index is the last assignment
    always_comb begin
        id_o    = '0;
        valid_o = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                id_o    = ID_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jac_int_ctrl.sv
// Memory-mapped interrupt controller: latches, masks and prioritises N_SRC requests.
module jac_int_ctrl
    import jac_mmio_pkg::*;
#(
    parameter int unsigned N_SRC     = 4,
    parameter logic [7:0]  BASE_ADDR = 8'd236
) (
    input  logic             wb_clk_i,
    input  logic             reset_n,
    input  logic [N_SRC-1:0] irq_src,
    jac_int_ctrl_if.slave    bus
);

    localparam int unsigned WIN = OFF_VEC0 + N_SRC;

    disp_state_e       state_q, state_d;
    logic [N_SRC-1:0]  ie_q, ie_d;
    logic [N_SRC-1:0]  ip_q, ip_d;
    logic [N_SRC-1:0]  mode_q, mode_d;
    logic [N_SRC-1:0]  irq_prev_q;
    logic              gie_q, gie_d;
    logic [DATA_W-1:0] vec_q [N_SRC];
    logic [DATA_W-1:0] vec_d [N_SRC];
    logic [ID_W-1:0]   id_q, id_d;
    logic              int_req_q, int_req_d;
    logic [DATA_W-1:0] int_en_q, int_en_d;
    logic [DATA_W-1:0] int_vec_q, int_vec_d;

    logic [DATA_W-1:0] off_c;
    logic              hit_c;
    logic              wr_ie_c, wr_ip_c, wr_mode_c, wr_ctrl_c;
    logic              eoi_c;
    logic              disp_c;
    logic [N_SRC-1:0]  cand_c;
    logic [ID_W-1:0]   enc_id_c;
    logic              enc_valid_c;
    logic [DATA_W-1:0] r_data_c;

    // Address decode for the register window
    always_comb begin
        off_c     = bus.addr - BASE_ADDR;
        hit_c     = (bus.addr >= BASE_ADDR) && (off_c < DATA_W'(WIN));
        wr_ie_c   = bus.w_en && hit_c && (off_c == DATA_W'(OFF_IE));
        wr_ip_c   = bus.w_en && hit_c && (off_c == DATA_W'(OFF_IP));
        wr_mode_c = bus.w_en && hit_c && (off_c == DATA_W'(OFF_MODE));
        wr_ctrl_c = bus.w_en && hit_c && (off_c == DATA_W'(OFF_CTRL));
        eoi_c     = wr_ctrl_c && bus.w_data[CTRL_EOI_BIT];
    end

    assign cand_c = ip_q & ie_q;

    jac_prio_enc #(.N(N_SRC)) u_prio (
        .req_i   (cand_c),
        .id_o    (enc_id_c),
        .valid_o (enc_valid_c)
    );

    // Combinational register read, zero outside the window
    always_comb begin
        r_data_c = '0;
        if (hit_c) begin
            if (off_c == DATA_W'(OFF_IE))   r_data_c = DATA_W'(ie_q);
            if (off_c == DATA_W'(OFF_IP))   r_data_c = DATA_W'(ip_q);
            if (off_c == DATA_W'(OFF_MODE)) r_data_c = DATA_W'(mode_q);
            if (off_c == DATA_W'(OFF_CTRL)) begin
                r_data_c[CTRL_SVC_BIT]                   = (state_q == ST_SERVICE);
                r_data_c[CTRL_ID_LSB +: ID_W]            = id_q;
                r_data_c[CTRL_GIE_BIT]                   = gie_q;
            end
            for (int i = 0; i < int'(N_SRC); i++) begin
                if (off_c == DATA_W'(OFF_VEC0 + i)) r_data_c = vec_q[i];
            end
        end
    end

    // Next-state: dispatch FSM, register writes, pending tracking
    always_comb begin
        state_d   = state_q;
        ie_d      = ie_q;
        ip_d      = ip_q;
        mode_d    = mode_q;
        gie_d     = gie_q;
        vec_d     = vec_q;
        id_d      = id_q;
        int_vec_d = int_vec_q;
        int_req_d = 1'b0;
        disp_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // EOI strobe in the same cycle suppresses dispatch
                if (gie_q && enc_valid_c && !eoi_c) begin
                    disp_c    = 1'b1;
                    state_d   = ST_SERVICE;
                    id_d      = enc_id_c;
                    int_req_d = 1'b1;
                    for (int i = 0; i < int'(N_SRC); i++) begin
                        if (enc_id_c == ID_W'(i)) int_vec_d = vec_q[i];
                    end
                end
            end
            ST_SERVICE: begin
                if (eoi_c) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (wr_ie_c)   ie_d   = bus.w_data[N_SRC-1:0];
        if (wr_mode_c) mode_d = bus.w_data[N_SRC-1:0];
        if (wr_ctrl_c) gie_d  = bus.w_data[CTRL_GIE_BIT];
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (bus.w_en && hit_c && (off_c == DATA_W'(OFF_VEC0 + i))) vec_d[i] = bus.w_data;
        end

        // Edge sources: new edge beats w1c and dispatch clear; level sources follow the pin
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (mode_q[i]) begin
                ip_d[i] = (irq_src[i] & ~irq_prev_q[i])
                        | (ip_q[i]
                           & ~(wr_ip_c & bus.w_data[i])
                           & ~(disp_c & (enc_id_c == ID_W'(i))));
            end else begin
                ip_d[i] = irq_src[i];
            end
        end

        int_en_d = DATA_W'(gie_d && (state_d == ST_IDLE));
    end

    // State and register update
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ie_q       <= '0;
            ip_q       <= '0;
            mode_q     <= '1;
            irq_prev_q <= '0;
            gie_q      <= 1'b0;
            vec_q      <= '{default: '0};
            id_q       <= '0;
            int_req_q  <= 1'b0;
            int_en_q   <= '0;
            int_vec_q  <= '0;
        end else begin
            state_q    <= state_d;
            ie_q       <= ie_d;
            ip_q       <= ip_d;
            mode_q     <= mode_d;
            irq_prev_q <= irq_src;
            gie_q      <= gie_d;
            vec_q      <= vec_d;
            id_q       <= id_d;
            int_req_q  <= int_req_d;
            int_en_q   <= int_en_d;
            int_vec_q  <= int_vec_d;
        end
    end

    assign bus.r_data  = r_data_c;
    assign bus.hit     = hit_c;
    assign bus.int_req = int_req_q;
    assign bus.int_en  = int_en_q;
    assign bus.int_vec = int_vec_q;

endmodule

// File: tb/tb_jac_int_ctrl.sv
// Directed self-checking bench for jac_int_ctrl (N_SRC=4, BASE_ADDR=236).
`timescale 1ns/100ps
module tb_jac_int_ctrl;

    localparam logic [7:0] A_IE   = 8'd236;
    localparam logic [7:0] A_IP   = 8'd237;
    localparam logic [7:0] A_MODE = 8'd238;
    localparam logic [7:0] A_CTRL = 8'd239;
    localparam logic [7:0] A_VEC0 = 8'd240;
    localparam logic [7:0] A_VEC1 = 8'd241;
    localparam logic [7:0] A_VEC2 = 8'd242;
    localparam logic [7:0] A_VEC3 = 8'd243;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] irq;
    int         n_checks = 0;
    int         n_errors = 0;

    jac_int_ctrl_if bus_if ();

    jac_int_ctrl #(.N_SRC(4), .BASE_ADDR(8'd236)) dut (
        .wb_clk_i (clk),
        .reset_n  (rst_n),
        .irq_src  (irq),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
        tick();
        bus_if.addr   = a;
        bus_if.w_data = d;
        bus_if.w_en   = 1'b1;
        tick();
        bus_if.w_en   = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
        bus_if.w_en = 1'b0;
        bus_if.addr = a;
        #1;
        check_eq(tag, bus_if.r_data, exp);
    endtask

    task automatic chk_hit(input string tag, input logic [7:0] a, input logic exp);
        bus_if.w_en = 1'b0;
        bus_if.addr = a;
        #1;
        check_eq(tag, 8'(bus_if.hit), 8'(exp));
    endtask

    initial begin
        rst_n         = 1'b0;
        irq           = '0;
        bus_if.addr   = '0;
        bus_if.w_data = '0;
        bus_if.w_en   = 1'b0;
        tick();
        tick();
        // Power-on reset values
        check_eq("rst_int_req", 8'(bus_if.int_req), 8'h00);
        check_eq("rst_int_en", bus_if.int_en, 8'h00);
        chk_rd("rst_mode", A_MODE, 8'h0F);
        chk_rd("rst_ie", A_IE, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();

        // Single edge source
        bus_wr(A_VEC1, 8'h40);
        bus_wr(A_IE, 8'h02);
        bus_wr(A_CTRL, 8'h01);
        check_eq("gie_int_en", bus_if.int_en, 8'h01);
        irq = 4'b0010;
        tick();
        irq = 4'b0000;
        check_eq("e_req_early", 8'(bus_if.int_req), 8'h00);
        chk_rd("e_ip_set", A_IP, 8'h02);
        tick();
        check_eq("e_req", 8'(bus_if.int_req), 8'h01);
        check_eq("e_vec", bus_if.int_vec, 8'h40);
        check_eq("e_int_en", bus_if.int_en, 8'h00);
        chk_rd("e_ip_clr", A_IP, 8'h00);
        chk_rd("e_ctrl", A_CTRL, 8'h91);
        tick();
        check_eq("e_req_pulse", 8'(bus_if.int_req), 8'h00);
        bus_wr(A_CTRL, 8'h03);
        check_eq("e_eoi_en", bus_if.int_en, 8'h01);
        chk_rd("e_eoi_ctrl", A_CTRL, 8'h11);

        // Priority: sources 1 and 3 together
        bus_wr(A_VEC3, 8'hC3);
        bus_wr(A_IE, 8'h0F);
        irq = 4'b1010;
        tick();
        irq = 4'b0000;
        chk_rd("p_ip", A_IP, 8'h0A);
        tick();
        check_eq("p_req1", 8'(bus_if.int_req), 8'h01);
        check_eq("p_vec1", bus_if.int_vec, 8'h40);
        chk_rd("p_ctrl1", A_CTRL, 8'h91);
        chk_rd("p_ip_left", A_IP, 8'h08);
        bus_wr(A_CTRL, 8'h03);
        check_eq("p_req_gap", 8'(bus_if.int_req), 8'h00);
        check_eq("p_en_gap", bus_if.int_en, 8'h01);
        tick();
        check_eq("p_req3", 8'(bus_if.int_req), 8'h01);
        check_eq("p_vec3", bus_if.int_vec, 8'hC3);
        chk_rd("p_ctrl3", A_CTRL, 8'hB1);
        bus_wr(A_CTRL, 8'h03);
        chk_rd("p_ip_empty", A_IP, 8'h00);

        // Level source on src2
        bus_wr(A_VEC2, 8'h22);
        bus_wr(A_MODE, 8'h0B);
        irq = 4'b0100;
        tick();
        tick();
        check_eq("l_req", 8'(bus_if.int_req), 8'h01);
        check_eq("l_vec", bus_if.int_vec, 8'h22);
        chk_rd("l_ip", A_IP, 8'h04);
        bus_wr(A_IP, 8'h04);
        chk_rd("l_w1c_ign", A_IP, 8'h04);
        bus_wr(A_CTRL, 8'h03);
        check_eq("l_eoi_req", 8'(bus_if.int_req), 8'h00);
        check_eq("l_eoi_en", bus_if.int_en, 8'h01);
        tick();
        check_eq("l_redisp", 8'(bus_if.int_req), 8'h01);
        irq = 4'b0000;
        bus_wr(A_CTRL, 8'h03);
        check_eq("l_drop_req", 8'(bus_if.int_req), 8'h00);
        chk_rd("l_drop_ip", A_IP, 8'h00);
        tick();
        check_eq("l_idle_req", 8'(bus_if.int_req), 8'h00);
        chk_rd("l_idle_ctrl", A_CTRL, 8'h21);

        // Masked source and set-vs-clear race
        bus_wr(A_IE, 8'h00);
        irq = 4'b0001;
        tick();
        irq = 4'b0000;
        tick();
        chk_rd("m_ip", A_IP, 8'h01);
        check_eq("m_no_req", 8'(bus_if.int_req), 8'h00);
        bus_wr(A_IP, 8'h01);
        chk_rd("m_w1c", A_IP, 8'h00);
        tick();
        irq           = 4'b0001;
        bus_if.addr   = A_IP;
        bus_if.w_data = 8'h01;
        bus_if.w_en   = 1'b1;
        tick();
        bus_if.w_en = 1'b0;
        irq         = 4'b0000;
        chk_rd("m_race", A_IP, 8'h01);
        bus_wr(A_IP, 8'h01);
        chk_rd("m_clean", A_IP, 8'h00);

        // Bus window edges and vector stability during service
        chk_hit("b_below", 8'd235, 1'b0);
        chk_rd("b_below_rd", 8'd235, 8'h00);
        chk_hit("b_above", 8'd244, 1'b0);
        tick();
        chk_rd("b_above_rd", 8'd244, 8'h00);
        chk_hit("b_last", A_VEC3, 1'b1);
        bus_wr(A_VEC0, 8'h10);
        bus_wr(A_IE, 8'h01);
        irq = 4'b0001;
        tick();
        irq = 4'b0000;
        tick();
        check_eq("b_req", 8'(bus_if.int_req), 8'h01);
        check_eq("b_vec", bus_if.int_vec, 8'h10);
        bus_wr(A_VEC0, 8'h77);
        check_eq("b_vec_hold", bus_if.int_vec, 8'h10);
        chk_rd("b_vec0_rd", A_VEC0, 8'h77);

        // GIE cleared during service
        bus_wr(A_CTRL, 8'h00);
        check_eq("g_en", bus_if.int_en, 8'h00);
        check_eq("g_vec", bus_if.int_vec, 8'h10);
        chk_rd("g_ctrl", A_CTRL, 8'h80);
        irq = 4'b0001;
        tick();
        irq = 4'b0000;
        tick();
        chk_rd("g_ip", A_IP, 8'h01);
        bus_wr(A_CTRL, 8'h02);
        check_eq("g_eoi_en", bus_if.int_en, 8'h00);
        chk_rd("g_eoi_ctrl", A_CTRL, 8'h00);
        tick();
        check_eq("g_no_req", 8'(bus_if.int_req), 8'h00);
        bus_wr(A_CTRL, 8'h01);
        check_eq("g_on_en", bus_if.int_en, 8'h01);
        check_eq("g_on_req0", 8'(bus_if.int_req), 8'h00);
        tick();
        check_eq("g_on_req", 8'(bus_if.int_req), 8'h01);
        check_eq("g_on_vec", bus_if.int_vec, 8'h77);
        check_eq("g_on_en0", bus_if.int_en, 8'h00);

        // Reset in the middle of service
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("r_int_req", 8'(bus_if.int_req), 8'h00);
        check_eq("r_int_en", bus_if.int_en, 8'h00);
        check_eq("r_int_vec", bus_if.int_vec, 8'h00);
        chk_rd("r_ie", A_IE, 8'h00);
        chk_rd("r_ip", A_IP, 8'h00);
        chk_rd("r_mode", A_MODE, 8'h0F);
        chk_rd("r_ctrl", A_CTRL, 8'h00);
        chk_rd("r_vec0", A_VEC0, 8'h00);
        chk_rd("r_vec1", A_VEC1, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("r_after_req", 8'(bus_if.int_req), 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
